// File: rtl/map_table_recovery_controller.sv
`default_nettype none
// ============================================================================
// Module      : map_table_recovery_controller
// Description : Branch-mispredict recovery sequencer for the physical
//               register map table and free list. It restores a checkpoint,
//               then walks squashed ROB entries youngest-first. It returns
//               speculated physical registers and, when the restore missed,
//               reverts map entries one by one. It forwards commit-time
//               checkpoint invalidations while idle.
// Revision    : 1.0 - initial release
// ============================================================================
module map_table_recovery_controller #(
  parameter int ROB_INDEX_W = 4,
  parameter int ARCH_TAG_W  = 5,
  parameter int PHYS_TAG_W  = 6,
  parameter int COL_W       = 2
) (
  input  logic                   CLK,
  input  logic                   RST,

  input  logic                   mispredict_valid,
  output logic                   mispredict_ready,
  input  logic [ROB_INDEX_W-1:0] mispredict_ROB_index,
  input  logic [COL_W-1:0]       mispredict_checkpoint_column,
  input  logic [ROB_INDEX_W-1:0] ROB_tail_index,

  input  logic                   commit_checkpoint_valid,
  output logic                   commit_checkpoint_ready,
  input  logic [ROB_INDEX_W-1:0] commit_checkpoint_ROB_index,
  input  logic [COL_W-1:0]       commit_checkpoint_column,

  output logic [ROB_INDEX_W-1:0] ROB_read_index,
  input  logic                   ROB_read_dest_valid,
  input  logic [ARCH_TAG_W-1:0]  ROB_read_dest_arch_reg_tag,
  input  logic [PHYS_TAG_W-1:0]  ROB_read_safe_phys_reg_tag,
  input  logic [PHYS_TAG_W-1:0]  ROB_read_speculated_phys_reg_tag,

  output logic                   revert_valid,
  output logic [ARCH_TAG_W-1:0]  revert_dest_arch_reg_tag,
  output logic [PHYS_TAG_W-1:0]  revert_safe_dest_phys_reg_tag,
  output logic [PHYS_TAG_W-1:0]  revert_speculated_dest_phys_reg_tag,

  output logic                   restore_checkpoint_valid,
  output logic                   restore_checkpoint_speculate_failed,
  output logic [ROB_INDEX_W-1:0] restore_checkpoint_ROB_index,
  output logic [COL_W-1:0]       restore_checkpoint_safe_column,
  input  logic                   restore_checkpoint_success,

  output logic                   free_list_return_valid,
  output logic [PHYS_TAG_W-1:0]  free_list_return_tag,

  output logic                   ROB_tail_rollback_valid,
  output logic [ROB_INDEX_W-1:0] ROB_tail_rollback_index,

  output logic                   dispatch_stall,
  output logic                   recovery_done
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RESTORE = 2'd1;
  localparam logic [1:0] S_WALK    = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]             r_state;
  logic [1:0]             w_next_state;
  logic [ROB_INDEX_W-1:0] r_br_idx;
  logic [COL_W-1:0]       r_col;
  logic [ROB_INDEX_W-1:0] r_walk_ptr;
  logic [ROB_INDEX_W-1:0] r_stop_idx;
  logic                   r_revert_mode;

  // State register; reset abandons any recovery in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: the walk ends on the entry just above the branch, or is
  // skipped entirely when the branch is the youngest ROB entry.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (mispredict_valid) w_next_state = S_RESTORE;
      S_RESTORE: w_next_state = (r_walk_ptr == r_br_idx) ? S_DONE : S_WALK;
      S_WALK:    if (r_walk_ptr == r_stop_idx) w_next_state = S_DONE;
      S_DONE:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Recovery context: latched on accept, walk pointer steps down mod 2^W.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_br_idx      <= '0;
      r_col         <= '0;
      r_walk_ptr    <= '0;
      r_stop_idx    <= '0;
      r_revert_mode <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mispredict_valid) begin
            r_br_idx   <= mispredict_ROB_index;
            r_col      <= mispredict_checkpoint_column;
            r_stop_idx <= mispredict_ROB_index + 1'b1;
            r_walk_ptr <= ROB_tail_index - 1'b1;
          end
        end
        S_RESTORE: r_revert_mode <= ~restore_checkpoint_success;
        S_WALK:    r_walk_ptr    <= r_walk_ptr - 1'b1;
        default:   ;
      endcase
    end
  end

  // Outputs; data fields stay zero unless their valid is asserted.
  always_comb begin
    mispredict_ready                    = 1'b0;
    commit_checkpoint_ready             = 1'b0;
    ROB_read_index                      = '0;
    revert_valid                        = 1'b0;
    revert_dest_arch_reg_tag            = '0;
    revert_safe_dest_phys_reg_tag       = '0;
    revert_speculated_dest_phys_reg_tag = '0;
    restore_checkpoint_valid            = 1'b0;
    restore_checkpoint_speculate_failed = 1'b0;
    restore_checkpoint_ROB_index        = '0;
    restore_checkpoint_safe_column      = '0;
    free_list_return_valid              = 1'b0;
    free_list_return_tag                = '0;
    ROB_tail_rollback_valid             = 1'b0;
    ROB_tail_rollback_index             = '0;
    dispatch_stall                      = 1'b0;
    recovery_done                       = 1'b0;
    case (r_state)
      S_IDLE: begin
        mispredict_ready        = 1'b1;
        dispatch_stall          = mispredict_valid;
        // A pending mispredict blocks commit forwarding this cycle.
        commit_checkpoint_ready = ~mispredict_valid;
        if (commit_checkpoint_valid && !mispredict_valid) begin
          restore_checkpoint_valid       = 1'b1;
          restore_checkpoint_ROB_index   = commit_checkpoint_ROB_index;
          restore_checkpoint_safe_column = commit_checkpoint_column;
        end
      end
      S_RESTORE: begin
        dispatch_stall                      = 1'b1;
        restore_checkpoint_valid            = 1'b1;
        restore_checkpoint_speculate_failed = 1'b1;
        restore_checkpoint_ROB_index        = r_br_idx;
        restore_checkpoint_safe_column      = r_col;
      end
      S_WALK: begin
        dispatch_stall = 1'b1;
        ROB_read_index = r_walk_ptr;
        if (ROB_read_dest_valid) begin
          free_list_return_valid = 1'b1;
          free_list_return_tag   = ROB_read_speculated_phys_reg_tag;
          if (r_revert_mode) begin
            revert_valid                        = 1'b1;
            revert_dest_arch_reg_tag            = ROB_read_dest_arch_reg_tag;
            revert_safe_dest_phys_reg_tag       = ROB_read_safe_phys_reg_tag;
            revert_speculated_dest_phys_reg_tag = ROB_read_speculated_phys_reg_tag;
          end
        end
      end
      S_DONE: begin
        dispatch_stall          = 1'b1;
        ROB_tail_rollback_valid = 1'b1;
        ROB_tail_rollback_index = r_stop_idx;
        recovery_done           = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_map_table_recovery_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_map_table_recovery_controller
// Description : Directed self-checking bench for the recovery controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_map_table_recovery_controller;

  logic       CLK = 1'b0;
  logic       RST;
  logic       mispredict_valid;
  logic       mispredict_ready;
  logic [3:0] mispredict_ROB_index;
  logic [1:0] mispredict_checkpoint_column;
  logic [3:0] ROB_tail_index;
  logic       commit_checkpoint_valid;
  logic       commit_checkpoint_ready;
  logic [3:0] commit_checkpoint_ROB_index;
  logic [1:0] commit_checkpoint_column;
  logic [3:0] ROB_read_index;
  logic       ROB_read_dest_valid;
  logic [4:0] ROB_read_dest_arch_reg_tag;
  logic [5:0] ROB_read_safe_phys_reg_tag;
  logic [5:0] ROB_read_speculated_phys_reg_tag;
  logic       revert_valid;
  logic [4:0] revert_dest_arch_reg_tag;
  logic [5:0] revert_safe_dest_phys_reg_tag;
  logic [5:0] revert_speculated_dest_phys_reg_tag;
  logic       restore_checkpoint_valid;
  logic       restore_checkpoint_speculate_failed;
  logic [3:0] restore_checkpoint_ROB_index;
  logic [1:0] restore_checkpoint_safe_column;
  logic       restore_checkpoint_success;
  logic       free_list_return_valid;
  logic [5:0] free_list_return_tag;
  logic       ROB_tail_rollback_valid;
  logic [3:0] ROB_tail_rollback_index;
  logic       dispatch_stall;
  logic       recovery_done;

  int total = 0;
  int bad   = 0;

  // ROB contents: arch = idx+10, safe = idx+20, speculated = idx+40.
  logic       rob_dv   [16];
  logic [4:0] rob_arch [16];
  logic [5:0] rob_safe [16];
  logic [5:0] rob_spec [16];

  assign ROB_read_dest_valid              = rob_dv[ROB_read_index];
  assign ROB_read_dest_arch_reg_tag       = rob_arch[ROB_read_index];
  assign ROB_read_safe_phys_reg_tag       = rob_safe[ROB_read_index];
  assign ROB_read_speculated_phys_reg_tag = rob_spec[ROB_read_index];

  always #5 CLK = ~CLK;

  map_table_recovery_controller dut (
    .CLK                                 (CLK),
    .RST                                 (RST),
    .mispredict_valid                    (mispredict_valid),
    .mispredict_ready                    (mispredict_ready),
    .mispredict_ROB_index                (mispredict_ROB_index),
    .mispredict_checkpoint_column        (mispredict_checkpoint_column),
    .ROB_tail_index                      (ROB_tail_index),
    .commit_checkpoint_valid             (commit_checkpoint_valid),
    .commit_checkpoint_ready             (commit_checkpoint_ready),
    .commit_checkpoint_ROB_index         (commit_checkpoint_ROB_index),
    .commit_checkpoint_column            (commit_checkpoint_column),
    .ROB_read_index                      (ROB_read_index),
    .ROB_read_dest_valid                 (ROB_read_dest_valid),
    .ROB_read_dest_arch_reg_tag          (ROB_read_dest_arch_reg_tag),
    .ROB_read_safe_phys_reg_tag          (ROB_read_safe_phys_reg_tag),
    .ROB_read_speculated_phys_reg_tag    (ROB_read_speculated_phys_reg_tag),
    .revert_valid                        (revert_valid),
    .revert_dest_arch_reg_tag            (revert_dest_arch_reg_tag),
    .revert_safe_dest_phys_reg_tag       (revert_safe_dest_phys_reg_tag),
    .revert_speculated_dest_phys_reg_tag (revert_speculated_dest_phys_reg_tag),
    .restore_checkpoint_valid            (restore_checkpoint_valid),
    .restore_checkpoint_speculate_failed (restore_checkpoint_speculate_failed),
    .restore_checkpoint_ROB_index        (restore_checkpoint_ROB_index),
    .restore_checkpoint_safe_column      (restore_checkpoint_safe_column),
    .restore_checkpoint_success          (restore_checkpoint_success),
    .free_list_return_valid              (free_list_return_valid),
    .free_list_return_tag                (free_list_return_tag),
    .ROB_tail_rollback_valid             (ROB_tail_rollback_valid),
    .ROB_tail_rollback_index             (ROB_tail_rollback_index),
    .dispatch_stall                      (dispatch_stall),
    .recovery_done                       (recovery_done)
  );

  // {stall, restore_valid, spec_failed, free_valid, revert_valid, rollback_valid, done}
  function automatic logic [6:0] flags();
    return {dispatch_stall, restore_checkpoint_valid, restore_checkpoint_speculate_failed,
            free_list_return_valid, revert_valid, ROB_tail_rollback_valid, recovery_done};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge; inputs change here.
  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic accept(input logic [3:0] br, input logic [1:0] col,
                        input logic [3:0] tail, input logic succ);
    mispredict_valid             = 1'b1;
    mispredict_ROB_index         = br;
    mispredict_checkpoint_column = col;
    ROB_tail_index               = tail;
    restore_checkpoint_success   = succ;
  endtask

  // One walk cycle: checks read address, free return and revert fields.
  task automatic walk_chk(input string tag, input logic [3:0] idx,
                          input logic fv, input logic rv,
                          input logic [5:0] ftag, input logic [4:0] arch,
                          input logic [5:0] safe);
    step(); #1;
    chk({tag, "_ridx"},  ROB_read_index, idx);
    chk({tag, "_flags"}, flags(), {1'b1, 2'b00, fv, rv, 2'b00});
    chk({tag, "_ftag"},  free_list_return_tag, fv ? ftag : 6'd0);
    if (rv) begin
      chk({tag, "_rarch"}, revert_dest_arch_reg_tag, arch);
      chk({tag, "_rsafe"}, revert_safe_dest_phys_reg_tag, safe);
      chk({tag, "_rspec"}, revert_speculated_dest_phys_reg_tag, ftag);
    end
  endtask

  initial begin
    int cyc;
    int frees;
    logic [3:0] first_idx;
    for (int i = 0; i < 16; i++) begin
      rob_dv[i]   = 1'b0;
      rob_arch[i] = 5'(i + 10);
      rob_safe[i] = 6'(i + 20);
      rob_spec[i] = 6'(i + 40);
    end
    RST = 1'b1;
    mispredict_valid = 1'b0; mispredict_ROB_index = '0; mispredict_checkpoint_column = '0;
    ROB_tail_index = '0; commit_checkpoint_valid = 1'b0; commit_checkpoint_ROB_index = '0;
    commit_checkpoint_column = '0; restore_checkpoint_success = 1'b0;
    step(); step();
    RST = 1'b0;
    #1;
    // Reset state
    chk("rst_flags", flags(), 7'b0000000);
    chk("rst_mready", mispredict_ready, 1);
    chk("rst_cready", commit_checkpoint_ready, 1);
    chk("rst_ridx", ROB_read_index, 0);

    // Checkpoint hit: br=3, tail=7, entries 6,5,4 valid
    rob_dv[4] = 1'b1; rob_dv[5] = 1'b1; rob_dv[6] = 1'b1;
    step(); accept(4'd3, 2'd2, 4'd7, 1'b1); #1;
    chk("hit_acc_flags", flags(), 7'b1000000);
    chk("hit_acc_cready", commit_checkpoint_ready, 0);
    step(); mispredict_valid = 1'b0; #1;
    chk("hit_rst_flags", flags(), 7'b1110000);
    chk("hit_rst_idx", restore_checkpoint_ROB_index, 3);
    chk("hit_rst_col", restore_checkpoint_safe_column, 2);
    chk("hit_rst_mready", mispredict_ready, 0);
    walk_chk("hit_w6", 4'd6, 1'b1, 1'b0, 6'd46, 5'd16, 6'd26);
    walk_chk("hit_w5", 4'd5, 1'b1, 1'b0, 6'd45, 5'd15, 6'd25);
    walk_chk("hit_w4", 4'd4, 1'b1, 1'b0, 6'd44, 5'd14, 6'd24);
    step(); #1;
    chk("hit_done_flags", flags(), 7'b1000011);
    chk("hit_done_rb", ROB_tail_rollback_index, 4);
    step(); #1;
    chk("hit_idle_flags", flags(), 7'b0000000);
    chk("hit_idle_mready", mispredict_ready, 1);

    // Checkpoint miss: same stimulus with success=0
    step(); accept(4'd3, 2'd2, 4'd7, 1'b0); #1;
    step(); mispredict_valid = 1'b0; #1;
    chk("miss_rst_flags", flags(), 7'b1110000);
    walk_chk("miss_w6", 4'd6, 1'b1, 1'b1, 6'd46, 5'd16, 6'd26);
    walk_chk("miss_w5", 4'd5, 1'b1, 1'b1, 6'd45, 5'd15, 6'd25);
    walk_chk("miss_w4", 4'd4, 1'b1, 1'b1, 6'd44, 5'd14, 6'd24);
    step(); #1;
    chk("miss_done_flags", flags(), 7'b1000011);
    chk("miss_done_rb", ROB_tail_rollback_index, 4);

    // Wrap plus skip: br=14, tail=2, entry 0 has no destination
    rob_dv[1] = 1'b1; rob_dv[0] = 1'b0; rob_dv[15] = 1'b1;
    step(); accept(4'd14, 2'd1, 4'd2, 1'b0); #1;
    chk("wrap_acc_flags", flags(), 7'b1000000);
    step(); mispredict_valid = 1'b0; #1;
    chk("wrap_rst_idx", restore_checkpoint_ROB_index, 14);
    walk_chk("wrap_w1",  4'd1,  1'b1, 1'b1, 6'd41, 5'd11, 6'd21);
    walk_chk("wrap_w0",  4'd0,  1'b0, 1'b0, 6'd40, 5'd10, 6'd20);
    walk_chk("wrap_w15", 4'd15, 1'b1, 1'b1, 6'd55, 5'd25, 6'd35);
    step(); #1;
    chk("wrap_done_flags", flags(), 7'b1000011);
    chk("wrap_done_rb", ROB_tail_rollback_index, 15);

    // Empty walk: br=9, tail=10
    step(); accept(4'd9, 2'd3, 4'd10, 1'b0); #1;
    step(); mispredict_valid = 1'b0; #1;
    chk("empty_rst_flags", flags(), 7'b1110000);
    step(); #1;
    chk("empty_done_flags", flags(), 7'b1000011);
    chk("empty_done_rb", ROB_tail_rollback_index, 10);
    step(); #1;
    chk("empty_idle_flags", flags(), 7'b0000000);

    // Priority: mispredict and commit together
    step(); accept(4'd9, 2'd0, 4'd10, 1'b1);
    commit_checkpoint_valid = 1'b1; commit_checkpoint_ROB_index = 4'd5; commit_checkpoint_column = 2'd1;
    #1;
    chk("prio_acc_cready", commit_checkpoint_ready, 0);
    chk("prio_acc_flags", flags(), 7'b1000000);
    step(); mispredict_valid = 1'b0; #1;
    chk("prio_rst_cready", commit_checkpoint_ready, 0);
    chk("prio_rst_flags", flags(), 7'b1110000);
    chk("prio_rst_idx", restore_checkpoint_ROB_index, 9);
    step(); #1;
    chk("prio_done_flags", flags(), 7'b1000011);
    step(); #1;
    chk("prio_fwd_cready", commit_checkpoint_ready, 1);
    chk("prio_fwd_flags", flags(), 7'b0100000);
    chk("prio_fwd_idx", restore_checkpoint_ROB_index, 5);
    chk("prio_fwd_col", restore_checkpoint_safe_column, 1);
    step(); commit_checkpoint_valid = 1'b0; #1;
    chk("prio_off_flags", flags(), 7'b0000000);

    // Asynchronous reset mid-walk
    step(); accept(4'd3, 2'd2, 4'd7, 1'b0); #1;
    step(); mispredict_valid = 1'b0; #1;
    walk_chk("arst_w6", 4'd6, 1'b1, 1'b1, 6'd46, 5'd16, 6'd26);
    RST = 1'b1; #1;
    chk("arst_flags", flags(), 7'b0000000);
    chk("arst_mready", mispredict_ready, 1);
    chk("arst_cready", commit_checkpoint_ready, 1);
    chk("arst_ridx", ROB_read_index, 0);
    chk("arst_rtag", revert_dest_arch_reg_tag, 0);
    step(); RST = 1'b0; #1;
    chk("arst_post_flags", flags(), 7'b0000000);

    // Full ROB after reset: br=tail=5, 15 entries walked
    for (int i = 0; i < 16; i++) rob_dv[i] = 1'b1;
    step(); accept(4'd5, 2'd0, 4'd5, 1'b1); #1;
    step(); mispredict_valid = 1'b0; #1;
    chk("full_rst_flags", flags(), 7'b1110000);
    cyc = 0; frees = 0; first_idx = '0;
    do begin
      step(); #1;
      cyc++;
      if (cyc == 1) first_idx = ROB_read_index;
      if (free_list_return_valid) frees++;
    end while (!recovery_done && cyc < 40);
    chk("full_cycles", cyc, 16);
    chk("full_frees", frees, 15);
    chk("full_first", first_idx, 4);
    chk("full_rb", ROB_tail_rollback_index, 6);
    step(); #1;
    chk("full_idle_flags", flags(), 7'b0000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
